// File: rtl/registrador_banco_ctl.sv
// Bank of independent WIDTH-bit register channels driven by per-channel 2-bit opcodes.
// Each channel supports clear, load, hold and count, and has a sticky overflow flag.
// A snapshot pulse copies every channel's pre-edge value into a shadow bank,
// and one shadow entry at a time is read back through a select input.
module registrador_banco_ctl #(
    parameter int WIDTH    = 6,
    parameter int CHANNELS = 4,
    parameter int SAT      = 0
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic [CHANNELS*WIDTH-1:0]                    in,
    input  logic [2*CHANNELS-1:0]                        T,
    input  logic                                         snap,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] rd_sel,
    output logic [CHANNELS*WIDTH-1:0]                    out,
    output logic [CHANNELS-1:0]                          ovf,
    output logic [WIDTH-1:0]                             snap_out,
    output logic                                         snap_valid
);

    localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_HOLD  = 2'b10;
    localparam logic [1:0] OP_COUNT = 2'b11;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] shadow_w [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [1:0]       op;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] val_q;
        logic [WIDTH-1:0] val_d;
        logic             ovf_q;
        logic             ovf_d;
        logic [WIDTH-1:0] shadow_q;
        logic [WIDTH:0]   inc;

        assign op  = T[2*k +: 2];
        assign din = in[k*WIDTH +: WIDTH];
        // The extra top bit is the carry; it only flags overflow, never reaches the value.
        assign inc = {1'b0, val_q} + {{WIDTH{1'b0}}, 1'b1};

        always_comb begin
            val_d = val_q;
            ovf_d = ovf_q;
            case (op)
                OP_CLEAR: begin
                    val_d = '0;
                    ovf_d = 1'b0;
                end
                OP_LOAD: begin
                    val_d = din;
                end
                OP_HOLD: begin
                    val_d = val_q;
                end
                OP_COUNT: begin
                    if (inc[WIDTH]) begin
                        ovf_d = 1'b1;
                        val_d = (SAT != 0) ? ALL_ONES : '0;
                    end else begin
                        val_d = inc[WIDTH-1:0];
                    end
                end
                default: begin
                    val_d = val_q;
                end
            endcase
        end

        // Shadow samples val_q, i.e. the value before this edge's update.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                val_q    <= '0;
                ovf_q    <= 1'b0;
                shadow_q <= '0;
            end else begin
                val_q <= val_d;
                ovf_q <= ovf_d;
                if (snap) begin
                    shadow_q <= val_q;
                end
            end
        end

        assign out[k*WIDTH +: WIDTH] = val_q;
        assign ovf[k]                = ovf_q;
        assign shadow_w[k]           = shadow_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_valid <= 1'b0;
        end else if (snap) begin
            snap_valid <= 1'b1;
        end
    end

    // Selects that name no existing channel fall through to zero.
    always_comb begin
        snap_out = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (rd_sel == SELW'(k)) begin
                snap_out = shadow_w[k];
            end
        end
    end

endmodule

// File: doc/registrador_banco_ctl.md
REGISTRADOR_BANCO_CTL -- requirements
Module: registrador_banco_ctl

Interface
REQ-001 Parameter WIDTH, default 6, channel data width in bits (legal 1..32).
REQ-002 Parameter CHANNELS, default 4, number of independent register channels (legal 1..16).
REQ-003 Parameter SAT, default 0, count-mode overflow policy: 0 = wrap to zero, 1 = saturate at all-ones.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port in  input  CHANNELS*WIDTH  load data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port T  input  2*CHANNELS  per-channel opcode; channel k occupies bits [2k +: 2].
REQ-008 Port snap  input  1  pulse; capture all channels into the shadow bank.
REQ-009 Port rd_sel  input  $clog2(CHANNELS) (min 1)  shadow read channel select.
REQ-010 Port out  output  CHANNELS*WIDTH  live registered channel values, same packing as in.
REQ-011 Port ovf  output  CHANNELS  sticky per-channel overflow flags, registered.
REQ-012 Port snap_out  output  WIDTH  shadow value of channel rd_sel, combinational from registered shadow.
REQ-013 Port snap_valid  output  1  registered; high once a snapshot has been taken since reset.

Function
REQ-014 Per-channel opcode decode at each rising clk edge: 00 CLEAR, 01 LOAD, 10 HOLD, 11 COUNT.
REQ-015 CLEAR: channel value <- 0; that channel's ovf <- 0.
REQ-016 LOAD: channel value <- its in slice; ovf unchanged.
REQ-017 HOLD: channel value and ovf unchanged (true register, no latch inferred in any path).
REQ-018 COUNT, value below all-ones: value <- value + 1; ovf unchanged.
REQ-019 COUNT, value all-ones, SAT=0: value <- 0; ovf <- 1.
REQ-020 COUNT, value all-ones, SAT=1: value stays all-ones; ovf <- 1.
REQ-021 ovf is sticky; only CLEAR on that channel or reset deasserts it.
REQ-022 Channels are fully independent; any opcode mix across channels in one cycle is legal.
REQ-023 Latency: out and ovf reflect the opcode one clock after it is presented; no combinational path from in or T to out.
REQ-024 snap=1 at an edge: shadow[k] <- out slice k as it was before that edge (pre-update value), for all k simultaneously.
REQ-025 snap=1 coincident with any opcode: shadow receives the old value; the channel update proceeds normally.
REQ-026 snap=0: shadow unchanged.
REQ-027 snap_valid <- 1 at the first edge with snap=1; it then stays 1 until reset.
REQ-028 snap_out = shadow[rd_sel]; rd_sel >= CHANNELS yields 0.
REQ-029 Arithmetic is unsigned and WIDTH bits; the increment carry is used only for overflow detection.

Reset
REQ-030 reset_n low asynchronously forces all channel values, all shadow entries, ovf and snap_valid to 0, regardless of clk.
REQ-031 While reset_n is low, T, in and snap are ignored.
REQ-032 Reset asserted mid-count or mid-snapshot discards the operation; there is no partial update.
REQ-033 The first edge after reset_n rises applies normal opcode decode.

Verification
REQ-034 Reset, then LOAD ch0=6'h2A, ch3=6'h15 with ch1/ch2 HOLD -> next cycle out ch0=0x2A, ch3=0x15, ch1=ch2=0.
REQ-035 SAT=0: LOAD ch1=6'h3E, then COUNT x3 -> values 0x3F, 0x00 (ovf[1]=1), 0x01; ovf[1] stays 1; CLEAR -> value 0, ovf[1]=0.
REQ-036 SAT=1: LOAD 6'h3F, then COUNT x2 -> value stays 0x3F, ovf=1 from the first COUNT.
REQ-037 ch2=0x10 with COUNT and snap=1 in the same cycle -> out ch2=0x11; rd_sel=2 gives snap_out=0x10; snap_valid=1.
REQ-038 Assert reset_n low between clock edges during a COUNT sequence -> out, ovf, snap_valid and snap_out go to 0 immediately, without waiting for a clock edge.
REQ-039 Run randomized opcodes on all channels for 1000 cycles against a reference model; also check CHANNELS=1 and WIDTH=1 builds.
